// File: rtl/riscv_instr_encoder_if.sv
// rtl/riscv_instr_encoder_if.sv - request/response bundle for riscv_instr_encoder
//
// Groups the request stream, the encoded-word stream and the address clear.
//   slave  : encoder view (consumes requests, produces words)
//   master : producer/consumer view (drives requests, accepts words)
// Parameter ADDR_W sets the width of out_addr and must match the encoder.
interface riscv_instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              clr_addr;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport slave (
    input  clr_addr, in_valid, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport master (
    output clr_addr, in_valid, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/riscv_instr_encoder.sv
// rtl/riscv_instr_encoder.sv - two-stage pipelined RV32I instruction encoder
//
// riscv_pkg  : opcode_e and instr_formats_e definitions.
// riscv_instr_encoder:
//   clk, rst  : clock, asynchronous active-high reset
//   bus.slave : clr_addr; in_valid/in_ready + opcode/funct3/funct7/rd/rs1/rs2/imm;
//               out_valid/out_ready + out_instr/out_addr/out_err
// Parameters: ADDR_W (address counter width), BASE_ADDR (counter reload value).
// Optional macro ENCODER_RANGE_CHECK_EN: also flag immediates that do not fit
// their format (the word is still encoded with truncation).
package riscv_pkg;
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_FENCE  = 7'b0001111,
    OPC_RI     = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_RR     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_EXCPT  = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    R_type = 3'd0,
    I_type = 3'd1,
    S_type = 3'd2,
    B_type = 3'd3,
    U_type = 3'd4,
    J_type = 3'd5,
    NONE_t = 3'd6
  } instr_formats_e;
endpackage

module riscv_instr_encoder
  import riscv_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_instr_encoder_if.slave  bus
);

  // Stage 1 registers
  logic           s1_valid_q,  s1_valid_d;
  instr_formats_e s1_fmt_q,    s1_fmt_d;
  logic [6:0]     s1_opcode_q, s1_opcode_d;
  logic [2:0]     s1_funct3_q, s1_funct3_d;
  logic [6:0]     s1_funct7_q, s1_funct7_d;
  logic [4:0]     s1_rd_q,     s1_rd_d;
  logic [4:0]     s1_rs1_q,    s1_rs1_d;
  logic [4:0]     s1_rs2_q,    s1_rs2_d;
  logic [31:0]    s1_imm_q,    s1_imm_d;

  // Stage 2 (output) registers and address counter
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic              out_err_q,   out_err_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;

  logic           s2_adv;
  logic           s1_adv;
  instr_formats_e in_fmt;
  logic           is_shift;
  logic [31:0]    enc_word;
  logic           enc_err;
  logic           rng_err;

  assign s2_adv = !out_valid_q || bus.out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_addr  = addr_q;

  always_comb begin
    in_fmt = NONE_t;
    case (bus.in_opcode)
      OPC_LUI, OPC_AUIPC:                        in_fmt = U_type;
      OPC_JAL:                                   in_fmt = J_type;
      OPC_JALR, OPC_LOAD, OPC_RI, OPC_FENCE,
      OPC_EXCPT:                                 in_fmt = I_type;
      OPC_BRANCH:                                in_fmt = B_type;
      OPC_STORE:                                 in_fmt = S_type;
      OPC_RR:                                    in_fmt = R_type;
      default:                                   in_fmt = NONE_t;
    endcase
  end

  // Stage 1 loads whenever it can advance; a bubble is loaded when in_valid is low.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_fmt_d    = s1_fmt_q;
    s1_opcode_d = s1_opcode_q;
    s1_funct3_d = s1_funct3_q;
    s1_funct7_d = s1_funct7_q;
    s1_rd_d     = s1_rd_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_imm_d    = s1_imm_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_fmt_d    = in_fmt;
        s1_opcode_d = bus.in_opcode;
        s1_funct3_d = bus.in_funct3;
        s1_funct7_d = bus.in_funct7;
        s1_rd_d     = bus.in_rd;
        s1_rs1_d    = bus.in_rs1;
        s1_rs2_d    = bus.in_rs2;
        s1_imm_d    = bus.in_imm;
      end
    end
  end

  // RI shifts carry funct7 and a 5-bit shamt in the immediate slot.
  assign is_shift = (s1_opcode_q == OPC_RI) &&
                    ((s1_funct3_q == 3'b001) || (s1_funct3_q == 3'b101));

`ifdef ENCODER_RANGE_CHECK_EN
  // An immediate fits N signed bits when bits [31:N-1] are all equal.
  always_comb begin
    rng_err = 1'b0;
    case (s1_fmt_q)
      I_type: rng_err = is_shift ? (|s1_imm_q[31:5])
                                 : !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
      S_type: rng_err = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
      B_type: rng_err = !((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12])) || s1_imm_q[0];
      J_type: rng_err = !((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20])) || s1_imm_q[0];
      U_type: rng_err = |s1_imm_q[11:0];
      default: rng_err = 1'b0;
    endcase
  end
`else
  assign rng_err = 1'b0;
`endif

  always_comb begin
    enc_word = 32'h0000_0013;
    enc_err  = rng_err;
    case (s1_fmt_q)
      R_type: enc_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      I_type: enc_word = is_shift
                ? {s1_funct7_q, s1_imm_q[4:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q}
                : {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      S_type: enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                          s1_imm_q[4:0], s1_opcode_q};
      B_type: enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                          s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
      U_type: enc_word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
      J_type: enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                          s1_rd_q, s1_opcode_q};
      default: begin
        enc_word = 32'h0000_0013;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Output register holds its word while the consumer stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_instr_d = enc_word;
        out_err_d   = enc_err;
      end
    end
  end

  // Clear wins over an increment in the same cycle; pipeline contents are kept.
  always_comb begin
    addr_d = addr_q;
    if (bus.clr_addr) begin
      addr_d = BASE_ADDR;
    end else if (out_valid_q && bus.out_ready) begin
      addr_d = addr_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= NONE_t;
      s1_opcode_q <= '0;
      s1_funct3_q <= '0;
      s1_funct7_q <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_imm_q    <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      addr_q      <= BASE_ADDR;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_opcode_q <= s1_opcode_d;
      s1_funct3_q <= s1_funct3_d;
      s1_funct7_q <= s1_funct7_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_imm_q    <= s1_imm_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      addr_q      <= addr_d;
    end
  end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// tb/tb_riscv_instr_encoder.sv - self-checking bench for riscv_instr_encoder
module tb_riscv_instr_encoder;
  import riscv_pkg::*;

`ifdef ENCODER_RANGE_CHECK_EN
  localparam bit RNG_ON = 1'b1;
`else
  localparam bit RNG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_instr_encoder_if #(.ADDR_W(32)) b ();
  riscv_instr_encoder_if #(.ADDR_W(4))  b4 ();

  riscv_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  riscv_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut4 (
    .clk(clk), .rst(rst), .bus(b4)
  );

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [31:0] exp_addr;
  logic        s_valid, s_err, s_in_ready, s_hs;
  logic [31:0] s_instr, s_addr;
  logic        stall_prev;
  logic [31:0] hold_instr, hold_addr;
  logic        hold_err;

  logic [6:0] ops[13] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                          OPC_STORE, OPC_RI, OPC_RR, OPC_FENCE, OPC_EXCPT, 7'h7F, 7'h00};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: places each field at its bit position by arithmetic from the ISA layout.
  function automatic logic [32:0] ref_word(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
    logic [31:0] w;
    logic        bad, rng;
    int          s;
    s   = $signed(imm);
    bad = 1'b0;
    rng = 1'b0;
    case (op)
      OPC_RR:
        w = (32'(f7) << 25) + (32'(rs2) << 20) + (32'(rs1) << 15) + (32'(f3) << 12)
          + (32'(rd) << 7) + 32'(op);
      OPC_RI, OPC_JALR, OPC_LOAD, OPC_FENCE, OPC_EXCPT:
        if (op == OPC_RI && (f3 == 3'd1 || f3 == 3'd5)) begin
          w = (32'(f7) << 25) + ((imm % 32) << 20) + (32'(rs1) << 15) + (32'(f3) << 12)
            + (32'(rd) << 7) + 32'(op);
          rng = imm > 31;
        end else begin
          w = ((imm % 4096) << 20) + (32'(rs1) << 15) + (32'(f3) << 12)
            + (32'(rd) << 7) + 32'(op);
          rng = s < -2048 || s > 2047;
        end
      OPC_STORE: begin
        w = (((imm / 32) % 128) << 25) + (32'(rs2) << 20) + (32'(rs1) << 15)
          + (32'(f3) << 12) + ((imm % 32) << 7) + 32'(op);
        rng = s < -2048 || s > 2047;
      end
      OPC_BRANCH: begin
        w = (((imm / 4096) % 2) << 31) + (((imm / 32) % 64) << 25) + (32'(rs2) << 20)
          + (32'(rs1) << 15) + (32'(f3) << 12) + (((imm / 2) % 16) << 8)
          + (((imm / 2048) % 2) << 7) + 32'(op);
        rng = s < -4096 || s > 4095 || (imm % 2) != 0;
      end
      OPC_LUI, OPC_AUIPC: begin
        w = (imm / 4096) * 4096 + (32'(rd) << 7) + 32'(op);
        rng = (imm % 4096) != 0;
      end
      OPC_JAL: begin
        w = (((imm / 1048576) % 2) << 31) + (((imm / 2) % 1024) << 21)
          + (((imm / 2048) % 2) << 20) + (((imm / 4096) % 256) << 12)
          + (32'(rd) << 7) + 32'(op);
        rng = s < -1048576 || s > 1048575 || (imm % 2) != 0;
      end
      default: begin
        w   = 32'h0000_0013;
        bad = 1'b1;
      end
    endcase
    return {bad || (RNG_ON && rng), w};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    b.in_valid  = 1'b1;
    b.in_opcode = op;
    b.in_funct3 = f3;
    b.in_funct7 = f7;
    b.in_rd     = rd;
    b.in_rs1    = rs1;
    b.in_rs2    = rs2;
    b.in_imm    = imm;
  endtask

  // One cycle: sample just after the negedge, score handshakes, wait for next negedge.
  task automatic tick();
    logic [32:0] e;
    #1;
    s_valid    = b.out_valid;
    s_instr    = b.out_instr;
    s_err      = b.out_err;
    s_addr     = b.out_addr;
    s_in_ready = b.in_ready;
    s_hs       = b.out_valid && b.out_ready;
    if (stall_prev) begin
      chk("hold_valid", b.out_valid, 1);
      chk("hold_instr", b.out_instr, hold_instr);
      chk("hold_err", b.out_err, hold_err);
      chk("hold_addr", b.out_addr, hold_addr);
    end
    stall_prev = b.out_valid && !b.out_ready;
    hold_instr = b.out_instr;
    hold_err   = b.out_err;
    hold_addr  = b.out_addr;
    if (s_hs) begin
      chk("word_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("instr", b.out_instr, e[31:0]);
        chk("err", b.out_err, e[32]);
        chk("addr", b.out_addr, exp_addr);
      end
      exp_addr = exp_addr + 4;
    end
    if (b.clr_addr) exp_addr = 32'h0;
    if (b.in_valid && b.in_ready)
      exp_q.push_back(ref_word(b.in_opcode, b.in_funct3, b.in_funct7, b.in_rd,
                               b.in_rs1, b.in_rs2, b.in_imm));
    @(negedge clk);
  endtask

  task automatic single(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] want, input logic want_err);
    int lat;
    bit found;
    b.out_ready = 1'b1;
    drive(op, f3, f7, rd, rs1, rs2, imm);
    tick();
    b.in_valid = 1'b0;
    chk({tag, "_accept"}, s_in_ready, 1);
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 8) begin
      tick();
      lat++;
      found = s_valid;
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_word"}, s_instr, want);
    chk({tag, "_err"}, s_err, want_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs[$];
    logic [3:0]  a4[$];
    logic [3:0]  want4[8];
    int idx, n4;
    bit saw_block, stale;

    b.clr_addr = 0; b.in_valid = 0; b.out_ready = 1;
    b.in_opcode = 0; b.in_funct3 = 0; b.in_funct7 = 0;
    b.in_rd = 0; b.in_rs1 = 0; b.in_rs2 = 0; b.in_imm = 0;
    b4.clr_addr = 0; b4.in_valid = 0; b4.out_ready = 1;
    b4.in_opcode = OPC_RI; b4.in_funct3 = 0; b4.in_funct7 = 0;
    b4.in_rd = 1; b4.in_rs1 = 0; b4.in_rs2 = 0; b4.in_imm = 1;
    exp_addr = 0; stall_prev = 0;

    // Reset state
    #1;
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_out_instr", b.out_instr, 0);
    chk("rst_out_err", b.out_err, 0);
    chk("rst_out_addr", b.out_addr, 0);
    chk("rst_in_ready", b.in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed single words
    single("addi", OPC_RI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    single("add", OPC_RR, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    single("lui", OPC_LUI, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5137, 1'b0);
    single("beq", OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463, 1'b0);
    single("sw", OPC_STORE, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'd12, 32'h0051_2623, 1'b0);
    single("jal", OPC_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 32'h0100_00EF, 1'b0);
    single("illegal", 7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd99, 32'h0000_0013, 1'b1);
    single("beq_odd", OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7, 32'h0020_8363, RNG_ON);

    // Back-to-back stream of 8 with a consumer stall on cycles 3-6
    b.clr_addr = 1'b1;
    tick();
    b.clr_addr = 1'b0;
    idx = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 40 && addrs.size() < 8; c++) begin
      b.out_ready = !(c >= 3 && c <= 6);
      if (idx < 8) drive(OPC_RI, 3'd0, 7'd0, 5'(idx + 1), 5'd0, 5'd0, 32'(idx * 3));
      else b.in_valid = 1'b0;
      tick();
      if (b.in_valid && s_in_ready) idx++;
      if (b.in_valid && !s_in_ready) saw_block = 1'b1;
      if (s_hs) addrs.push_back(s_addr);
    end
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    chk("stream_count", addrs.size(), 8);
    foreach (addrs[i]) chk("stream_addr", addrs[i], 32'(4 * i));
    chk("stream_in_ready_drop", saw_block, 1);
    chk("stream_drained", exp_q.size(), 0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      int m;
      logic [31:0] imm;
      m = $urandom_range(0, 3);
      imm = (m == 0) ? $urandom() :
            (m == 1) ? 32'($signed($urandom_range(0, 8191)) - 4096) :
            (m == 2) ? 32'($urandom_range(0, 40)) : ($urandom() & 32'hFFFF_F000);
      drive(ops[$urandom_range(0, 12)], 3'($urandom()), 7'($urandom()), 5'($urandom()),
            5'($urandom()), 5'($urandom()), imm);
      b.in_valid  = ($urandom_range(0, 3) != 0);
      b.out_ready = ($urandom_range(0, 3) != 0);
      b.clr_addr  = b.out_ready && ($urandom_range(0, 31) == 0);
      tick();
    end
    b.in_valid = 1'b0;
    b.clr_addr = 1'b0;
    b.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("random_drained", exp_q.size(), 0);

    // ADDR_W=4 wrap and clear-with-handshake
    want4 = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd0, 4'd4, 4'd8, 4'd0};
    n4 = 0;
    for (int c = 0; c < 30 && a4.size() < 8; c++) begin
      b4.in_valid = (n4 < 8);
      #1;
      if (b4.in_valid && b4.in_ready) n4++;
      b4.clr_addr = 1'b0;
      if (b4.out_valid && b4.out_ready) begin
        a4.push_back(b4.out_addr);
        if (a4.size() == 7) b4.clr_addr = 1'b1;
      end
      @(negedge clk);
    end
    b4.in_valid = 1'b0;
    b4.clr_addr = 1'b0;
    chk("wrap_count", a4.size(), 8);
    foreach (a4[i]) chk("wrap_addr", a4[i], want4[i]);

    // Reset with both stages full
    b.out_ready = 1'b0;
    drive(OPC_RR, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0);
    tick();
    tick();
    b.in_valid = 1'b0;
    #1;
    chk("full_out_valid", b.out_valid, 1);
    chk("full_in_ready", b.in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_drops_valid", b.out_valid, 0);
    exp_q.delete();
    exp_addr = 0;
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    b.out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", b.in_ready, 1);
    chk("post_rst_addr", b.out_addr, 0);
    @(negedge clk);
    stale = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      stale = stale | s_valid;
    end
    chk("post_rst_no_stale", stale, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
